// File: rtl/uart_prog_loader.sv
`timescale 1ns/1ps
// uart_prog_loader
// Receives 8N1 serial bytes on uart_in, packs them into WORD_BYTES-wide words
// and drives the instruction-memory write port. The CPU is held in reset while
// a load is in progress.
//
// Optional feature macro: UART_PROG_LOADER_CHECKSUM_EN
//   defined   : one extra byte after the data must equal the 8-bit sum of all
//               data bytes; a mismatch sets chk_err; done is set on its arrival.
//   undefined : no checksum byte, chk_err tied low.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   uart_in      serial RX line (idle high, asynchronous to clk)
//   load_start   pulse: arm a load of load_len words from address 0 (0 = full depth)
//   load_len     word count, captured on load_start
//   load_abort   pulse: terminate an active load immediately
//   mem_we       one-cycle write strobe; mem_addr / mem_wdata valid with it
//   busy         load in progress
//   done         sticky, set on successful completion
//   frame_err    sticky, a stop bit was sampled low
//   cpu_rst_n    registered ~busy
//   chk_err      sticky checksum mismatch (optional feature)
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 870,
    parameter int WORD_BYTES   = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_in,
    input  logic                    load_start,
    input  logic [ADDR_WIDTH:0]     load_len,
    input  logic                    load_abort,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    frame_err,
    output logic                    cpu_rst_n,
    output logic                    chk_err
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIDX_W-1:0]   BYTE_LAST = BIDX_W'(WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [1:0] L_IDLE = 2'd0;
    localparam logic [1:0] L_LOAD = 2'd1;
    localparam logic [1:0] L_DONE = 2'd2;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to the idle-high line level)
    // ------------------------------------------------------------------
    logic rxMeta, rxSync;

    // NOTE: registers use non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= uart_in;
            rxSync <= rxMeta;
        end
    end

    // ------------------------------------------------------------------
    // 8N1 receiver: start bit re-checked at mid-bit, then one sample per bit
    // ------------------------------------------------------------------
    logic [1:0]       rxState;
    logic [CNT_W-1:0] clkCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       rxShift;
    logic             byteValid;
    logic             stopErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxState   <= R_IDLE;
            clkCnt    <= '0;
            bitCnt    <= '0;
            rxShift   <= '0;
            byteValid <= 1'b0;
            stopErr   <= 1'b0;
        end else begin
            byteValid <= 1'b0;
            stopErr   <= 1'b0;
            case (rxState)
                R_IDLE: begin
                    clkCnt <= '0;
                    if (!rxSync) rxState <= R_START;
                end
                R_START: begin
                    if (clkCnt == HALF_LAST) begin
                        clkCnt  <= '0;
                        bitCnt  <= '0;
                        // A line already back high at mid-bit was a glitch.
                        rxState <= rxSync ? R_IDLE : R_DATA;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (clkCnt == BIT_LAST) begin
                        clkCnt  <= '0;
                        rxShift <= {rxSync, rxShift[7:1]};
                        bitCnt  <= bitCnt + 1'b1;
                        if (bitCnt == 3'd7) rxState <= R_STOP;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (clkCnt == BIT_LAST) begin
                        clkCnt    <= '0;
                        byteValid <= rxSync;
                        stopErr   <= ~rxSync;
                        rxState   <= R_IDLE;
                    end else begin
                        clkCnt <= clkCnt + 1'b1;
                    end
                end
                default: rxState <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Word assembly
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] wordBuf, nextWord;

    // NOTE: both branches assign nextWord, so no latch is inferred.
    always_comb begin
        if (MSB_FIRST) nextWord = (wordBuf << 8) | DATA_W'(rxShift);
        else           nextWord = (wordBuf >> 8) | (DATA_W'(rxShift) << (DATA_W - 8));
    end

    // ------------------------------------------------------------------
    // Loader control
    // ------------------------------------------------------------------
    logic [1:0]            lState;
    logic [ADDR_WIDTH:0]   lenWords, wordIdx;
    logic [BIDX_W-1:0]     byteIdx;
    logic                  allWritten;

    assign allWritten = (wordIdx == lenWords);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    logic [7:0] chkSum;
    logic       chkErrR;
    assign chk_err = chkErrR;
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lState    <= L_IDLE;
            lenWords  <= '0;
            wordIdx   <= '0;
            byteIdx   <= '0;
            wordBuf   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            cpu_rst_n <= 1'b1;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            chkSum    <= '0;
            chkErrR   <= 1'b0;
`endif
        end else begin
            mem_we    <= 1'b0;
            cpu_rst_n <= ~busy;
            if (stopErr) frame_err <= 1'b1;

            case (lState)
                L_IDLE, L_DONE: begin
                    if (load_start) begin
                        lenWords  <= (load_len == '0) ? DEPTH : load_len;
                        wordIdx   <= '0;
                        byteIdx   <= '0;
                        done      <= 1'b0;
                        frame_err <= 1'b0;
                        busy      <= 1'b1;
                        lState    <= L_LOAD;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                        chkSum    <= '0;
                        chkErrR   <= 1'b0;
`endif
                    end
                end
                L_LOAD: begin
                    if (load_abort) begin
                        // Checked first so a coincident last byte never writes.
                        lState <= L_IDLE;
                        busy   <= 1'b0;
                    end else if (byteValid && !allWritten) begin
                        wordBuf <= nextWord;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                        chkSum  <= chkSum + rxShift;
`endif
                        if (byteIdx == BYTE_LAST) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wordIdx[ADDR_WIDTH-1:0];
                            mem_wdata <= nextWord;
                            wordIdx   <= wordIdx + 1'b1;
                            byteIdx   <= '0;
                        end else begin
                            byteIdx <= byteIdx + 1'b1;
                        end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                    end else if (byteValid && allWritten) begin
                        // The byte after the last data word is the checksum.
                        chkErrR <= (rxShift != chkSum);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        lState  <= L_DONE;
                    end
`else
                    end else if (mem_we && allWritten) begin
                        // Leave only after the last word's write cycle.
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        lState <= L_DONE;
                    end
`endif
                end
                default: lState <= L_IDLE;
            endcase
        end
    end

endmodule
